ex_mem_reg: RTL and testbench
=============================

# ex_mem_reg

EX/MEM pipeline stage register for the LEGv8 pipelined CPU. It captures the 64-bit ALU result and Zero flag produced by the execute-stage ALU, together with store data, destination register, branch target and memory/writeback control. It also resolves conditional and unconditional branches and presents a registered redirect to the fetch stage. The block supports stall (hold) and flush (bubble insertion) under hazard-unit control.

## Interface

Parameters:
- N, 63: MSB index of data paths, giving 64-bit words.

Ports:
- CLK  in  1  rising-edge clock.
- Reset_L  in  1  asynchronous, active-low reset.
- Stall  in  1  hold all stage contents.
- Flush  in  1  replace captured instruction with a bubble; has priority over Stall.
- InValid  in  1  the EX-stage instruction is real, not a bubble.
- ALUResult  in  N+1  ALU output (BusW).
- Zero  in  1  ALU zero flag.
- StoreData  in  N+1  register Rt value for STUR.
- BranchTarget  in  N+1  PC + (imm<<2) computed in EX.
- Rd  in  5  destination register index.
- RegWrite, MemRead, MemWrite, MemToReg  in  1 each  writeback/memory controls.
- Branch, UncondBranch, BranchNZ  in  1 each  CBZ/CBNZ/B decode (BranchNZ=1 selects CBNZ).
- OutValid  out  1  captured instruction is real.
- ALUResultM, StoreDataM, BranchTargetM  out  N+1  registered copies.
- RdM  out  5.
- RegWriteM, MemReadM, MemWriteM, MemToRegM  out  1 each.
- PCSrc  out  1  branch taken; fetch must load BranchTargetM.

## Operation

- Priority on each rising CLK edge is Flush, then Stall, then capture.
- Flush=1:
  - OutValid, all four control outputs and PCSrc go to 0.
  - Data outputs (ALUResultM, StoreDataM, BranchTargetM, RdM) go to 0.
- Flush=0, Stall=1: every output holds its value, including PCSrc.
- Capture (Flush=0, Stall=0):
  - OutValid <= InValid.
  - Data and RdM are loaded unconditionally.
  - Control outputs are loaded as input AND InValid, so a bubble never writes memory or registers.
  - PCSrc <= InValid & (UncondBranch | (Branch & (Zero ^ BranchNZ))).
    - CBZ is taken on Zero=1.
    - CBNZ is taken on Zero=0.
    - B is always taken.
- Rd=31 (XZR) is stored unchanged. Suppressing the write is the register file's job.
- There is no arithmetic in this block except the optional counters below.

## Timing

- Latency is 1 cycle: inputs sampled at edge k appear on the outputs after edge k.
- ALU results carry a 20 ns behavioural delay and Zero a further 1 ns. Inputs must settle before the sampling edge, so the clock period is at least 25 ns.
- Reset_L=0 forces all outputs to 0 immediately, independent of CLK, and holds them while low.
- Reset during a stall discards the held instruction.
- Release of Reset_L is synchronous in effect: the first capture happens on the first rising edge with Reset_L=1.
- PCSrc is high for exactly one cycle per taken branch, unless Stall extends it.
- Flush and Stall asserted together means flush.
- Stall asserted on consecutive cycles holds indefinitely.

## Configuration

- Macro EXMEM_PERF_CNT_EN.
- Defined:
  - Adds outputs InstCount[31:0] and TakenCount[31:0]; both reset to 0.
  - On each capture edge, InstCount increments if InValid=1.
  - On each capture edge, TakenCount increments if the new PCSrc=1.
  - Counters hold on Stall and on Flush.
  - Counters wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counter logic are absent, and behaviour is otherwise identical.

## Test plan

- Reset:
  - Drive Reset_L=0 mid-cycle with OutValid=1 and RegWriteM=1.
  - Required: all outputs 0 within the same cycle, and they stay 0 until the first edge after release.
- Normal capture:
  - Inputs: ALUResult=0x0000_0000_0000_0010, Rd=9, RegWrite=1, InValid=1.
  - Required: next cycle ALUResultM=0x10, RdM=9, RegWriteM=1, OutValid=1, PCSrc=0.
- Branch resolution:
  - Branch=1, Zero=1, BranchNZ=0 gives PCSrc=1.
  - Same with BranchNZ=1 gives PCSrc=0.
  - UncondBranch=1 with Zero=0 gives PCSrc=1.
  - Each taken case has BranchTargetM equal to the applied target.
- Bubble gating:
  - InValid=0 with MemWrite=1 and RegWrite=1.
  - Required: MemWriteM=0, RegWriteM=0, OutValid=0.
- Stall then flush:
  - Capture an instruction, then Stall=1 for 3 cycles with changing inputs.
  - Required: outputs unchanged.
  - Then Stall=1 and Flush=1 together: OutValid=0 and PCSrc=0 next cycle.
- With EXMEM_PERF_CNT_EN:
  - Preload InstCount to 0xFFFFFFFF via 2^32-1 valid captures, or force in simulation.
  - One more valid capture gives InstCount=0.
  - Stall and flush cycles leave both counters unchanged.

Source files
------------

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: LEGv8 EX/MEM stage register with branch resolution; `define EXMEM_PERF_CNT_EN adds InstCount/TakenCount
module ex_mem_reg #(
  parameter int N = 63
) (
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic       Stall,
  input  logic       Flush,
  input  logic       InValid,
  input  logic [N:0] ALUResult,
  input  logic       Zero,
  input  logic [N:0] StoreData,
  input  logic [N:0] BranchTarget,
  input  logic [4:0] Rd,
  input  logic       RegWrite,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic       MemToReg,
  input  logic       Branch,
  input  logic       UncondBranch,
  input  logic       BranchNZ,
  output logic       OutValid,
  output logic [N:0] ALUResultM,
  output logic [N:0] StoreDataM,
  output logic [N:0] BranchTargetM,
  output logic [4:0] RdM,
  output logic       RegWriteM,
  output logic       MemReadM,
  output logic       MemWriteM,
  output logic       MemToRegM,
  output logic       PCSrc
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0] InstCount,
  output logic [31:0] TakenCount
`endif
);
  logic pc_nxt;
  assign pc_nxt = InValid & (UncondBranch | (Branch & (Zero ^ BranchNZ)));
  // Stage register: flush inserts an all-zero bubble, stall holds, otherwise capture with controls gated by InValid
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L || Flush) begin
      OutValid      <= 1'b0;
      ALUResultM    <= '0;
      StoreDataM    <= '0;
      BranchTargetM <= '0;
      RdM           <= '0;
      RegWriteM     <= 1'b0;
      MemReadM      <= 1'b0;
      MemWriteM     <= 1'b0;
      MemToRegM     <= 1'b0;
      PCSrc         <= 1'b0;
    end else if (!Stall) begin
      OutValid      <= InValid;
      ALUResultM    <= ALUResult;
      StoreDataM    <= StoreData;
      BranchTargetM <= BranchTarget;
      RdM           <= Rd;
      RegWriteM     <= RegWrite & InValid;
      MemReadM      <= MemRead & InValid;
      MemWriteM     <= MemWrite & InValid;
      MemToRegM     <= MemToReg & InValid;
      PCSrc         <= pc_nxt;
    end
  end
`ifdef EXMEM_PERF_CNT_EN
  // Count real instructions and taken branches on capture edges only; wrap naturally
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      InstCount  <= '0;
      TakenCount <= '0;
    end else if (!Flush && !Stall) begin
      InstCount  <= InstCount + {31'b0, InValid};
      TakenCount <= TakenCount + {31'b0, pc_nxt};
    end
  end
`endif
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: table-driven, hand-sequenced and randomized checks of ex_mem_reg against a rule-level model
module tb_ex_mem_reg;
  typedef struct packed {
    logic iv; logic [63:0] alu; logic z; logic [63:0] sd; logic [63:0] bt; logic [4:0] rd;
    logic rw, mr, mw, m2r, br, ub, bnz, st, fl;
  } in_t;
  typedef struct packed {
    logic ov; logic [63:0] alu; logic [63:0] sd; logic [63:0] bt; logic [4:0] rd;
    logic rw, mr, mw, m2r, pc;
  } out_t;
  typedef struct { string name; in_t i; out_t e; } vec_t;

  logic CLK = 0, Reset_L = 0;
  in_t d = '0;
  logic OutValid, RegWriteM, MemReadM, MemWriteM, MemToRegM, PCSrc;
  logic [63:0] ALUResultM, StoreDataM, BranchTargetM;
  logic [4:0] RdM;
  int checks = 0, failures = 0;
  out_t exp_q = '0;

  always #15 CLK = ~CLK;

  ex_mem_reg #(.N(63)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Stall(d.st), .Flush(d.fl), .InValid(d.iv),
    .ALUResult(d.alu), .Zero(d.z), .StoreData(d.sd), .BranchTarget(d.bt), .Rd(d.rd),
    .RegWrite(d.rw), .MemRead(d.mr), .MemWrite(d.mw), .MemToReg(d.m2r),
    .Branch(d.br), .UncondBranch(d.ub), .BranchNZ(d.bnz),
    .OutValid(OutValid), .ALUResultM(ALUResultM), .StoreDataM(StoreDataM),
    .BranchTargetM(BranchTargetM), .RdM(RdM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .PCSrc(PCSrc)
  );

  function automatic out_t model(out_t q, in_t i);
    out_t r;
    if (i.fl) return '0;
    if (i.st) return q;
    r.ov = i.iv; r.alu = i.alu; r.sd = i.sd; r.bt = i.bt; r.rd = i.rd;
    r.rw = i.iv && i.rw; r.mr = i.iv && i.mr; r.mw = i.iv && i.mw; r.m2r = i.iv && i.m2r;
    if (!i.iv) r.pc = 0;
    else if (i.ub) r.pc = 1;
    else if (i.br) r.pc = i.bnz ? !i.z : i.z;
    else r.pc = 0;
    return r;
  endfunction

  function automatic in_t mk_in(logic iv, logic [63:0] alu, logic z, logic [63:0] bt, logic [4:0] rd,
                                logic rw, logic mw, logic br, logic ub, logic bnz);
    in_t r = '0;
    r.iv = iv; r.alu = alu; r.z = z; r.sd = ~alu; r.bt = bt; r.rd = rd;
    r.rw = rw; r.mw = mw; r.br = br; r.ub = ub; r.bnz = bnz;
    return r;
  endfunction

  function automatic out_t mk_out(logic ov, logic [63:0] alu, logic [63:0] bt, logic [4:0] rd,
                                  logic rw, logic mw, logic pc);
    out_t r = '0;
    r.ov = ov; r.alu = alu; r.sd = ~alu; r.bt = bt; r.rd = rd; r.rw = rw; r.mw = mw; r.pc = pc;
    return r;
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  task automatic cmp_all(string tag, out_t e);
    chk({tag, ".OutValid"}, 64'(OutValid), 64'(e.ov));
    chk({tag, ".ALUResultM"}, ALUResultM, e.alu);
    chk({tag, ".StoreDataM"}, StoreDataM, e.sd);
    chk({tag, ".BranchTargetM"}, BranchTargetM, e.bt);
    chk({tag, ".RdM"}, 64'(RdM), 64'(e.rd));
    chk({tag, ".RegWriteM"}, 64'(RegWriteM), 64'(e.rw));
    chk({tag, ".MemReadM"}, 64'(MemReadM), 64'(e.mr));
    chk({tag, ".MemWriteM"}, 64'(MemWriteM), 64'(e.mw));
    chk({tag, ".MemToRegM"}, 64'(MemToRegM), 64'(e.m2r));
    chk({tag, ".PCSrc"}, 64'(PCSrc), 64'(e.pc));
  endtask

  task automatic step(in_t i);
    d = i;
    @(posedge CLK);
    exp_q = model(exp_q, i);
    @(negedge CLK);
  endtask

  vec_t v[7];
  initial begin
    v[0] = '{"capture", mk_in(1, 64'h10, 0, 64'h0, 9, 1, 0, 0, 0, 0), mk_out(1, 64'h10, 64'h0, 9, 1, 0, 0)};
    v[1] = '{"cbz_taken", mk_in(1, 64'h0, 1, 64'h1000, 3, 0, 0, 1, 0, 0), mk_out(1, 64'h0, 64'h1000, 3, 0, 0, 1)};
    v[2] = '{"cbnz_not", mk_in(1, 64'h0, 1, 64'h1100, 4, 0, 0, 1, 0, 1), mk_out(1, 64'h0, 64'h1100, 4, 0, 0, 0)};
    v[3] = '{"b_taken", mk_in(1, 64'h5, 0, 64'h2000, 5, 0, 0, 0, 1, 0), mk_out(1, 64'h5, 64'h2000, 5, 0, 0, 1)};
    v[4] = '{"bubble", mk_in(0, 64'h77, 0, 64'h3000, 6, 1, 1, 0, 1, 0), mk_out(0, 64'h77, 64'h3000, 6, 0, 0, 0)};
    v[5] = '{"cbnz_taken", mk_in(1, 64'h9, 0, 64'h4000, 7, 0, 1, 1, 0, 1), mk_out(1, 64'h9, 64'h4000, 7, 0, 1, 1)};
    v[6] = '{"xzr", mk_in(1, 64'hdead, 0, 64'h0, 31, 1, 0, 0, 0, 0), mk_out(1, 64'hdead, 64'h0, 31, 1, 0, 0)};

    // Reset state
    #7 cmp_all("reset0", '0);
    @(negedge CLK); Reset_L = 1;
    step(mk_in(1, 64'h10, 0, 64'h0, 9, 1, 0, 0, 0, 0));
    chk("pre_reset.OutValid", 64'(OutValid), 1);
    chk("pre_reset.RegWriteM", 64'(RegWriteM), 1);
    // Asynchronous reset mid-cycle
    #4 Reset_L = 0;
    #1 cmp_all("async_rst", '0);
    exp_q = '0;
    @(posedge CLK); #1 cmp_all("rst_hold", '0);
    @(negedge CLK); Reset_L = 1;
    #2 cmp_all("rst_release", '0);
    @(negedge CLK);

    // Table vectors
    foreach (v[k]) begin
      step(v[k].i);
      cmp_all(v[k].name, v[k].e);
      cmp_all({v[k].name, "_model"}, exp_q);
    end

    // Stall for 3 cycles with changing inputs, then stall+flush
    step(mk_in(1, 64'habc, 1, 64'h5000, 12, 1, 0, 1, 0, 0));
    cmp_all("pre_stall", mk_out(1, 64'habc, 64'h5000, 12, 1, 0, 1));
    for (int s = 0; s < 3; s++) begin
      in_t r = mk_in(1, {$urandom, $urandom}, 0, {$urandom, $urandom}, 5'(s), 1, 1, 0, 1, 0);
      r.st = 1;
      step(r);
      cmp_all($sformatf("stall%0d", s), mk_out(1, 64'habc, 64'h5000, 12, 1, 0, 1));
    end
    begin
      in_t r = mk_in(1, 64'h1, 0, 64'h1, 1, 1, 1, 0, 1, 0);
      r.st = 1; r.fl = 1;
      step(r);
      cmp_all("stall_flush", '0);
    end

    // Reset during a stall discards the held instruction
    step(mk_in(1, 64'h42, 0, 64'h0, 2, 1, 0, 0, 1, 0));
    d.st = 1;
    #3 Reset_L = 0;
    #1 cmp_all("rst_in_stall", '0);
    exp_q = '0;
    @(negedge CLK); Reset_L = 1;
    d.st = 0;
    step(d);
    cmp_all("after_stall_rst", exp_q);

    // Randomized run against the model
    for (int n = 0; n < 300; n++) begin
      in_t r;
      r.iv = ($urandom_range(3) != 0);
      r.alu = {$urandom, $urandom}; r.z = 1'($urandom); r.sd = {$urandom, $urandom};
      r.bt = {$urandom, $urandom}; r.rd = 5'($urandom);
      r.rw = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom); r.m2r = 1'($urandom);
      r.br = 1'($urandom); r.ub = ($urandom_range(3) == 0); r.bnz = 1'($urandom);
      r.st = ($urandom_range(4) == 0); r.fl = ($urandom_range(7) == 0);
      step(r);
      cmp_all($sformatf("rnd%0d", n), exp_q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
